// File: rtl/alu_mdu_pkg.sv
// Shared encodings for the ALU / multiply-divide unit: funct codes, ALUOp codes,
// internal ALU-control code and FSM states.
package alu_mdu_pkg;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic [3:0] {
    CTRL_NONE, CTRL_ADD, CTRL_SUB, CTRL_AND, CTRL_OR, CTRL_NOR, CTRL_SLT,
    CTRL_SLTU, CTRL_MFHI, CTRL_MFLO, CTRL_MULT, CTRL_MULTU, CTRL_DIV, CTRL_DIVU
  } ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE, ST_MUL, ST_DIV, ST_FIN
  } state_e;

endpackage

// File: rtl/alu_mdu_unit_ctrl.sv
// alu_ctrl_decode: combinational ALUOp/funct to control-code mapping.
module alu_ctrl_decode
  import alu_mdu_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output ctrl_e      ctrl_o,
  output logic       is_multi_o,
  output logic       illegal_o
);

  always_comb begin
    ctrl_o     = CTRL_NONE;
    is_multi_o = 1'b0;
    illegal_o  = 1'b0;
    case (alu_op_i)
      ALUOP_ADD: ctrl_o = CTRL_ADD;
      ALUOP_SUB: ctrl_o = CTRL_SUB;
      default: begin
        case (funct_i)
          F_ADD:   ctrl_o = CTRL_ADD;
          F_SUB:   ctrl_o = CTRL_SUB;
          F_AND:   ctrl_o = CTRL_AND;
          F_OR:    ctrl_o = CTRL_OR;
          F_NOR:   ctrl_o = CTRL_NOR;
          F_SLT:   ctrl_o = CTRL_SLT;
          F_SLTU:  ctrl_o = CTRL_SLTU;
          F_MFHI:  ctrl_o = CTRL_MFHI;
          F_MFLO:  ctrl_o = CTRL_MFLO;
          F_MULT:  begin ctrl_o = CTRL_MULT;  is_multi_o = 1'b1; end
          F_MULTU: begin ctrl_o = CTRL_MULTU; is_multi_o = 1'b1; end
          F_DIV:   begin ctrl_o = CTRL_DIV;   is_multi_o = 1'b1; end
          F_DIVU:  begin ctrl_o = CTRL_DIVU;  is_multi_o = 1'b1; end
          default: illegal_o = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_mdu_unit.sv
// Single-cycle ALU plus iterative (1 bit/cycle) multiply/divide writing HI/LO.
// state | meaning: IDLE wait accept | MUL shift-add step | DIV restoring step | FIN sign-fix, write HI/LO, done
module alu_mdu_unit
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

  ctrl_e  ctrl;
  logic   is_multi, illegal_dec;
  state_e state_q, state_d;

  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, hi_q, lo_q, hi_d, lo_d, res;
  logic               is_div_q, res_neg_q, rem_neg_q, div_zero_q;

  alu_ctrl_decode u_dec (
    .alu_op_i   (ALUOp),
    .funct_i    (funct),
    .ctrl_o     (ctrl),
    .is_multi_o (is_multi),
    .illegal_o  (illegal_dec)
  );

  always_comb begin
    res = '0;
    case (ctrl)
      CTRL_ADD:  res = a + b;
      CTRL_SUB:  res = a - b;
      CTRL_AND:  res = a & b;
      CTRL_OR:   res = a | b;
      CTRL_NOR:  res = ~(a | b);
      CTRL_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      CTRL_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
      CTRL_MFHI: res = hi_q;
      CTRL_MFLO: res = lo_q;
      default:   res = '0;
    endcase
  end

  assign result  = res;
  assign zero    = (res == '0);
  assign illegal = illegal_dec;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_FIN);
  assign hi      = hi_q;
  assign lo      = lo_q;

  logic             accept, op_signed, op_div, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign accept    = valid_in && ALUOp[1] && is_multi && (state_q == ST_IDLE);
  assign op_signed = (ctrl == CTRL_MULT) || (ctrl == CTRL_DIV);
  assign op_div    = (ctrl == CTRL_DIV) || (ctrl == CTRL_DIVU);
  assign a_neg     = op_signed && a[WIDTH-1];
  assign b_neg     = op_signed && b[WIDTH-1];
  assign mag_a     = a_neg ? -a : a;
  assign mag_b     = b_neg ? -b : b;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = op_div ? ST_DIV : ST_MUL;
      ST_MUL,
      ST_DIV:  if (cnt_q == CW'(1)) state_d = ST_FIN;
      default: state_d = ST_IDLE;
    endcase
  end

  // acc_q holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  logic [WIDTH:0]       upper, shifted, diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo, rem;

  always_comb begin
    upper   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff    = shifted - {1'b0, mcand_q};
    acc_d   = acc_q;
    if (state_q == ST_MUL)
      acc_d = {upper, acc_q[WIDTH-1:1]};
    else if (state_q == ST_DIV)
      acc_d = diff[WIDTH] ? {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                          : {diff[WIDTH-1:0],    acc_q[WIDTH-2:0], 1'b1};
    prod_fix = res_neg_q ? -acc_q : acc_q;
    quo      = acc_q[WIDTH-1:0];
    rem      = acc_q[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      lo_d = div_zero_q ? '1 : (res_neg_q ? -quo : quo);
      hi_d = rem_neg_q ? -rem : rem;
    end else begin
      lo_d = prod_fix[WIDTH-1:0];
      hi_d = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      res_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (accept) begin
      cnt_q      <= CNT_LOAD;
      acc_q      <= {{WIDTH{1'b0}}, op_div ? mag_a : mag_b};
      mcand_q    <= op_div ? mag_b : mag_a;
      is_div_q   <= op_div;
      res_neg_q  <= a_neg ^ b_neg;
      rem_neg_q  <= a_neg;
      div_zero_q <= (b == '0);
    end else if (state_q == ST_MUL || state_q == ST_DIV) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q - CW'(1);
    end else if (state_q == ST_FIN) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu_unit.sv
// Randomized self-checking bench for alu_mdu_unit (WIDTH=32) against an arithmetic reference model.
module tb_alu_mdu_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset, valid_in;
  logic [1:0]    ALUOp;
  logic [5:0]    funct;
  logic [W-1:0]  a, b, result, hi, lo;
  logic          zero, busy, done, illegal;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [W-1:0]  m_hi = '0;
  logic [W-1:0]  m_lo = '0;

  always #5 clk = ~clk;

  alu_mdu_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ALUOp(ALUOp), .funct(funct),
    .a(a), .b(b), .result(result), .zero(zero), .busy(busy), .done(done),
    .illegal(illegal), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_alu(input logic [1:0] op, input logic [5:0] f,
                                  input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic ill);
    longint sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    r = '0;
    ill = 1'b0;
    if (op == 2'b00) r = x + y;
    else if (op == 2'b01) r = x - y;
    else begin
      case (f)
        6'h20: r = x + y;
        6'h22: r = x - y;
        6'h24: r = x & y;
        6'h25: r = x | y;
        6'h27: r = ~(x | y);
        6'h2A: r = (sx < sy) ? 1 : 0;
        6'h2B: r = (x < y) ? 1 : 0;
        6'h10: r = m_hi;
        6'h12: r = m_lo;
        6'h18, 6'h19, 6'h1A, 6'h1B: r = '0;
        default: ill = 1'b1;
      endcase
    end
  endfunction

  function automatic void ref_multi(input logic [5:0] f, input logic [W-1:0] x,
                                    input logic [W-1:0] y,
                                    output logic [W-1:0] h, output logic [W-1:0] l);
    longint sx, sy, q, r;
    longint unsigned ux, uy, uq, ur;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'b0, x};
    uy = {32'b0, y};
    p = '0;
    case (f)
      6'h18: p = sx * sy;
      6'h19: p = ux * uy;
      6'h1A: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else begin
          uq = ux / uy;
          ur = ux % uy;
          p = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    h = p[63:32];
    l = p[31:0];
  endfunction

  task automatic do_single(input logic [1:0] op, input logic [5:0] f,
                           input logic [W-1:0] x, input logic [W-1:0] y, input logic vin);
    logic [W-1:0] er;
    logic         eill;
    ALUOp = op; funct = f; a = x; b = y; valid_in = vin;
    #3;
    ref_alu(op, f, x, y, er, eill);
    check("result", result, er);
    check("zero", zero, er == 0);
    check("illegal", illegal, eill);
    step();
    valid_in = 1'b0;
    if (vin) begin
      check("no_start_busy", busy, 0);
      check("hi_kept", hi, m_hi);
      check("lo_kept", lo, m_lo);
    end
  endtask

  task automatic run_multi(input logic [5:0] f, input logic [W-1:0] x,
                           input logic [W-1:0] y, input bit probe);
    logic [W-1:0] eh, el;
    int n, extra, tail;
    ref_multi(f, x, y, eh, el);
    ALUOp = 2'b10; funct = f; a = x; b = y; valid_in = 1'b1;
    step();
    valid_in = 1'b0; a = $urandom; b = $urandom;
    n = 1;
    check("busy_after_accept", busy, 1);
    while (!done && n < W + 8) begin
      if (probe && n == 5) begin
        funct = 6'h10;
        #3;
        check("mfhi_while_busy", result, m_hi);
        funct = f; a = $urandom; b = $urandom; valid_in = 1'b1;
      end
      step();
      valid_in = 1'b0;
      n++;
    end
    check("latency", n, W + 1);
    step();
    check("done_one_cycle", done, 0);
    check("busy_cleared", busy, 0);
    check("hi", hi, eh);
    check("lo", lo, el);
    m_hi = eh;
    m_lo = el;
    extra = 0;
    tail = probe ? W + 5 : 2;
    for (int i = 0; i < tail; i++) begin
      step();
      if (done) extra++;
    end
    check("extra_done", extra, 0);
  endtask

  logic [5:0] sc_f [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B, 6'h10, 6'h12, 6'h3F};
  logic [5:0] mc_f [4]  = '{6'h18, 6'h19, 6'h1A, 6'h1B};

  initial begin
    logic [W-1:0] x, y;
    logic [5:0]   f;
    int           extra;
    reset = 1'b1; valid_in = 1'b0; ALUOp = 2'b00; funct = 6'h00; a = '0; b = '0;
    step(); step();
    reset = 1'b0;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    do_single(2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1, 1'b0);
    do_single(2'b10, 6'h2B, 32'hFFFF_FFFF, 32'd1, 1'b0);
    do_single(2'b00, 6'h00, 32'hFFFF_FFFF, 32'd1, 1'b0);
    do_single(2'b01, 6'h3F, 32'd5, 32'd5, 1'b0);

    run_multi(6'h18, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_multi(6'h19, 32'hFFFF_FFFF, 32'd2, 1'b1);
    run_multi(6'h1A, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_multi(6'h1B, 32'd7, 32'd0, 1'b0);
    run_multi(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_multi(6'h1A, 32'hFFFF_FFF9, 32'd0, 1'b0);

    do_single(2'b10, 6'h3F, $urandom, $urandom, 1'b1);

    for (int i = 0; i < 40; i++) begin
      f = sc_f[$urandom_range(0, 9)];
      do_single(2'($urandom_range(0, 3)), f, $urandom, (i % 5 == 0) ? 32'd0 : $urandom,
                1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 10; i++) begin
      f = mc_f[$urandom_range(0, 3)];
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 3))
        0: ;
        1: begin x = $urandom_range(0, 200) - 100; y = $urandom_range(1, 20) - 10; end
        2: y = '0;
        default: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      endcase
      run_multi(f, x, y, (i == 3));
    end

    // abort a multiply mid-flight
    ALUOp = 2'b10; funct = 6'h18; a = $urandom; b = $urandom; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    m_hi = '0;
    m_lo = '0;
    extra = 0;
    for (int i = 0; i < W + 5; i++) begin
      step();
      if (done) extra++;
    end
    check("abort_no_done", extra, 0);

    run_multi(6'h19, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);

    // reset wins over a simultaneous accept
    reset = 1'b1; valid_in = 1'b1; ALUOp = 2'b10; funct = 6'h1B; a = 32'd9; b = 32'd2;
    step();
    reset = 1'b0; valid_in = 1'b0;
    check("rst_vs_accept_busy", busy, 0);
    check("rst_vs_accept_hi", hi, 0);
    m_hi = '0;
    m_lo = '0;
    step();
    check("rst_vs_accept_busy2", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_mdu_unit.md
ALU_MDU_UNIT -- requirements
Module: alu_mdu_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath width in bits (legal values 8 to 64, even).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port valid_in  input  1  operation request qualifier.
REQ-005 SHALL have port ALUOp  input  2  00 add, 01 sub, 1X decode by funct.
REQ-006 SHALL have port funct  input  6  R-type function field.
REQ-007 SHALL have ports a, b  input  WIDTH  operands (a = rs, b = rt).
REQ-008 SHALL have port result  output  WIDTH  combinational single-cycle result.
REQ-009 SHALL have port zero  output  1  high when result equals 0.
REQ-010 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse on multi-cycle completion.
REQ-012 SHALL have port illegal  output  1  high when ALUOp is 1X and funct is unsupported.
REQ-013 SHALL have ports hi, lo  output  WIDTH  HI/LO register contents.

Function
REQ-014 SHALL decode funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt (signed), 0x2B sltu (unsigned); result is valid in the same cycle, with wrap-around add/sub and no overflow trap.
REQ-015 SHALL return hi for funct 0x10 (mfhi) and lo for funct 0x12 (mflo), combinationally from the registers.
REQ-016 SHALL drive result to 0 and illegal to 1 for an unsupported funct; no state changes.
REQ-017 SHALL treat funct 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu as multi-cycle; accepted only when valid_in=1, ALUOp=1X and busy=0.
REQ-018 SHALL implement FSM states IDLE -> MUL or DIV on accept -> FIN -> IDLE.
REQ-019 SHALL iterate one bit per cycle, WIDTH cycles in MUL/DIV, using shift-add multiply and restoring divide on operand magnitudes; signed variants sign-correct in FIN.
REQ-020 SHALL assert busy from the cycle after accept through FIN inclusive; done high only in the FIN cycle; accept-to-done latency is WIDTH+1 cycles.
REQ-021 SHALL update hi/lo only in FIN: mult* gives the {hi,lo} 2*WIDTH-bit product; div* gives lo = quotient truncated toward zero and hi = remainder with the sign of the dividend.
REQ-022 SHALL, on divide by zero, set lo = all ones and hi = a, at the normal latency.
REQ-023 SHALL ignore valid_in while busy=1; single-cycle ops still evaluate combinationally, and mfhi/mflo return the pre-operation hi/lo.
REQ-024 SHALL latch operands at accept; later changes to a and b do not affect the operation.
REQ-025 SHALL produce a signed result of 0x8000_0000 / 0xFFFF_FFFF (WIDTH=32) of lo = 0x8000_0000, hi = 0, with no trap.

Reset
REQ-026 SHALL, when reset=1 at a clock edge, enter IDLE and clear hi, lo, busy, done and the iteration counter to 0, including when reset arrives mid-operation (the operation is aborted; hi/lo are not updated).
REQ-027 SHALL give reset priority over a simultaneous valid_in accept.

Structure
REQ-028 SHALL place funct codes, ALUOp codes, the internal ALU-control encoding and the FSM state encoding in shared package alu_mdu_pkg.
REQ-029 SHALL split the ALUOp/funct-to-control mapping into combinational sub-module alu_ctrl_decode, which outputs the control code, is_multi and illegal.
REQ-030 SHALL size the iteration counter as clog2(WIDTH)+1 bits.

Verification
REQ-031 SHALL cover: WIDTH=32, slt a=0xFFFFFFFF b=1 -> result=1; sltu with the same operands -> result=0, zero=1.
REQ-032 SHALL cover: mult a=0xFFFFFFFF b=2 -> done at cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu with the same operands -> hi=1, lo=0xFFFFFFFE.
REQ-033 SHALL cover: div a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7 b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-034 SHALL cover: mfhi issued while busy -> returns the old hi; a second mult during busy is ignored, producing exactly one done pulse.
REQ-035 SHALL cover: reset asserted at cycle 10 of a mult -> next cycle busy=0, hi=lo=0, and no done pulse.
REQ-036 SHALL cover: funct=0x3F with ALUOp=10 -> illegal=1, result=0, hi/lo unchanged.
